// File: rtl/systolic_result_writer_if.sv
// Memory write-port bundle between the result writer (master) and unified memory (slave).
// Lane i of writedata targets word write_addr+i when write_mask[i] is set.
interface systolic_result_writer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int WRITE_BW   = 4
);
  logic                           write;
  logic                           write_ready;
  logic [ADDR_WIDTH-1:0]          write_addr;
  logic [WRITE_BW*DATA_WIDTH-1:0] writedata;
  logic [WRITE_BW-1:0]            write_mask;

  modport master (
    output write, write_addr, writedata, write_mask,
    input  write_ready
  );

  modport slave (
    input  write, write_addr, writedata, write_mask,
    output write_ready
  );
endinterface

// File: rtl/systolic_result_writer.sv
// Snapshots an ARR x ARR result tile and streams it row-major, densely packed,
// to unified memory in WRITE_BW-word beats under a ready/valid handshake.
module systolic_result_writer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int WRITE_BW   = 4,
  parameter int ARR        = 8,
  parameter int DIM_WIDTH  = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_C,
  input  logic [DIM_WIDTH-1:0]          dim_row,
  input  logic [DIM_WIDTH-1:0]          dim_col,
  input  logic [ARR*ARR*DATA_WIDTH-1:0] In,
  systolic_result_writer_if.master      mem,
  output logic                          busy,
  output logic                          done
);

  localparam int TILE_W = ARR*ARR*DATA_WIDTH;
  localparam int BEAT_W = WRITE_BW*DATA_WIDTH;

  typedef enum logic {IDLE, WRITE} state_t;

  function automatic logic [DIM_WIDTH-1:0] clamp_dim(input logic [DIM_WIDTH-1:0] d);
    return (d > DIM_WIDTH'(ARR)) ? DIM_WIDTH'(ARR) : d;
  endfunction

  function automatic logic [DIM_WIDTH-1:0] beats_per_row(input logic [DIM_WIDTH-1:0] c);
    return DIM_WIDTH'((int'(c) + WRITE_BW - 1) / WRITE_BW);
  endfunction

  // Lanes past the last column are forced to zero rather than carrying stale tile data.
  function automatic logic [BEAT_W-1:0] lane_data(input logic [TILE_W-1:0] tile,
                                                  input int r, input int k, input int c);
    logic [BEAT_W-1:0] d;
    int col;
    d = '0;
    for (int i = 0; i < WRITE_BW; i++) begin
      col = WRITE_BW*k + i;
      if (col < c)
        d[i*DATA_WIDTH +: DATA_WIDTH] = tile[(r*ARR + col)*DATA_WIDTH +: DATA_WIDTH];
    end
    return d;
  endfunction

  function automatic logic [WRITE_BW-1:0] lane_mask(input int k, input int c);
    logic [WRITE_BW-1:0] m;
    for (int i = 0; i < WRITE_BW; i++)
      m[i] = (WRITE_BW*k + i) < c;
    return m;
  endfunction

  state_t                state;
  logic [TILE_W-1:0]     tile;
  logic [DIM_WIDTH-1:0]  rows;
  logic [DIM_WIDTH-1:0]  cols;
  logic [DIM_WIDTH-1:0]  nbeats;
  logic [DIM_WIDTH-1:0]  row_idx;
  logic [DIM_WIDTH-1:0]  beat_idx;
  logic [ADDR_WIDTH-1:0] row_base;

  logic                  vld_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [BEAT_W-1:0]     data_p0;
  logic [WRITE_BW-1:0]   mask_p0;

  logic [DIM_WIDTH-1:0]  req_rows;
  logic [DIM_WIDTH-1:0]  req_cols;
  logic                  last_in_row;
  logic                  last_row;
  logic [ADDR_WIDTH-1:0] next_row_base;

  assign req_rows      = clamp_dim(dim_row);
  assign req_cols      = clamp_dim(dim_col);
  assign last_in_row   = (beat_idx == nbeats - DIM_WIDTH'(1));
  assign last_row      = (row_idx == rows - DIM_WIDTH'(1));
  assign next_row_base = row_base + ADDR_WIDTH'(cols);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      vld_p0   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_p0  <= '0;
      data_p0  <= '0;
      mask_p0  <= '0;
      row_idx  <= '0;
      beat_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tile     <= In;
            rows     <= req_rows;
            cols     <= req_cols;
            nbeats   <= beats_per_row(req_cols);
            row_base <= base_C;
            row_idx  <= '0;
            beat_idx <= '0;
            if (req_rows == '0 || req_cols == '0) begin
              done <= 1'b1;
            end else begin
              // Beat 0 is built straight from the live bus; the snapshot lands this same edge.
              state   <= WRITE;
              vld_p0  <= 1'b1;
              busy    <= 1'b1;
              addr_p0 <= base_C;
              data_p0 <= lane_data(In, 0, 0, int'(req_cols));
              mask_p0 <= lane_mask(0, int'(req_cols));
            end
          end
        end

        WRITE: begin
          if (mem.write_ready) begin
            if (last_in_row && last_row) begin
              state  <= IDLE;
              vld_p0 <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else if (last_in_row) begin
              row_idx  <= row_idx + DIM_WIDTH'(1);
              beat_idx <= '0;
              row_base <= next_row_base;
              addr_p0  <= next_row_base;
              data_p0  <= lane_data(tile, int'(row_idx) + 1, 0, int'(cols));
              mask_p0  <= lane_mask(0, int'(cols));
            end else begin
              beat_idx <= beat_idx + DIM_WIDTH'(1);
              addr_p0  <= addr_p0 + ADDR_WIDTH'(WRITE_BW);
              data_p0  <= lane_data(tile, int'(row_idx), int'(beat_idx) + 1, int'(cols));
              mask_p0  <= lane_mask(int'(beat_idx) + 1, int'(cols));
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign mem.write      = vld_p0;
  assign mem.write_addr = addr_p0;
  assign mem.writedata  = data_p0;
  assign mem.write_mask = mask_p0;

endmodule

// File: tb/tb_systolic_result_writer.sv
// Bench for systolic_result_writer: table of directed tile transfers, hand-written
// backpressure/reset/start-while-busy sequences, and randomized runs against a beat-list model.
module tb_systolic_result_writer;

  logic          clock;
  logic          reset;
  logic          start;
  logic [11:0]   base_C;
  logic [5:0]    dim_row;
  logic [5:0]    dim_col;
  logic [2047:0] In;
  logic          busy;
  logic          done;

  systolic_result_writer_if mem ();

  systolic_result_writer dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .base_C  (base_C),
    .dim_row (dim_row),
    .dim_col (dim_col),
    .In      (In),
    .mem     (mem),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0]  addr;
    logic [127:0] data;
    logic [3:0]   mask;
  } beat_t;

  typedef struct {
    logic [5:0]   dr;
    logic [5:0]   dc;
    logic [11:0]  base;
    int           nbeats;
    logic [127:0] first_data;
    logic [11:0]  addr1;
    logic [11:0]  last_addr;
    logic [3:0]   last_mask;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] tile_m [8][8];
  beat_t       exp_q[$];
  beat_t       rec_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [2047:0] pack_tile();
    logic [2047:0] t;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        t[(r*8 + c)*32 +: 32] = tile_m[r][c];
    return t;
  endfunction

  // Reference: walk the clamped tile row by row in WRITE_BW-column chunks.
  task automatic build_expected(input logic [11:0] base, input int dr, input int dc);
    int nr, nc;
    beat_t b;
    nr = (dr > 8) ? 8 : dr;
    nc = (dc > 8) ? 8 : dc;
    exp_q.delete();
    for (int r = 0; r < nr; r++)
      for (int c0 = 0; c0 < nc; c0 += 4) begin
        b.addr = 12'((int'(base) + r*nc + c0) % 4096);
        b.data = '0;
        b.mask = '0;
        for (int i = 0; i < 4; i++)
          if (c0 + i < nc) begin
            b.data[i*32 +: 32] = tile_m[r][c0 + i];
            b.mask[i] = 1'b1;
          end
        exp_q.push_back(b);
      end
  endtask

  // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: random ready.
  task automatic run(input logic [11:0] base, input logic [5:0] dr, input logic [5:0] dc,
                     input int mode, input int reset_at, input int busy_start_at,
                     output int nbusy, output int done_idx);
    int    cyc, acc;
    bit    stalled, bs_fired;
    beat_t held, cur;
    build_expected(base, int'(dr), int'(dc));
    rec_q.delete();
    nbusy = 0; done_idx = -1; cyc = 0; acc = 0; stalled = 0; bs_fired = 0;
    @(negedge clock);
    base_C = base; dim_row = dr; dim_col = dc; In = pack_tile(); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int w = 0; w < 64; w++) In[w*32 +: 32] = $urandom;
    base_C = 12'($urandom); dim_row = 6'($urandom); dim_col = 6'($urandom);
    while (cyc < 400) begin
      if (reset_at >= 0 && acc == reset_at) begin
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_write", mem.write, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_addr", mem.write_addr, 0);
        check("rst_mid_data", mem.writedata, 0);
        check("rst_mid_mask", mem.write_mask, 0);
        @(negedge clock);
        check("rst_no_done", done, 0);
        return;
      end
      case (mode)
        0:       mem.write_ready = 1'b1;
        1:       mem.write_ready = (cyc % 3 == 0);
        default: mem.write_ready = 1'($urandom_range(0, 1));
      endcase
      if (busy_start_at >= 0 && acc == busy_start_at && !bs_fired) begin
        start = 1'b1; base_C = 12'd0; dim_row = 6'd2; dim_col = 6'd2; bs_fired = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cur.addr = mem.write_addr; cur.data = mem.writedata; cur.mask = mem.write_mask;
      check("busy_vs_write", busy, mem.write);
      if (mem.write) begin
        nbusy++;
        if (stalled) begin
          check("hold_addr", cur.addr, held.addr);
          check("hold_data", cur.data, held.data);
          check("hold_mask", cur.mask, held.mask);
        end
        if (acc < exp_q.size()) begin
          check("beat_addr", cur.addr, exp_q[acc].addr);
          check("beat_data", cur.data, exp_q[acc].data);
          check("beat_mask", cur.mask, exp_q[acc].mask);
        end else begin
          check("extra_beat", acc, exp_q.size());
        end
      end
      if (done) begin
        done_idx = cyc;
        check("done_after_last", acc, exp_q.size());
        check("done_timing", cyc, nbusy);
        break;
      end
      if (mem.write && mem.write_ready) begin
        rec_q.push_back(cur);
        acc++;
        stalled = 0;
      end else if (mem.write) begin
        stalled = 1;
        held = cur;
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    if (done_idx < 0) begin
      check("done_timeout", 0, 1);
    end else begin
      @(negedge clock);
      check("done_pulse_width", done, 0);
      check("idle_write", mem.write, 0);
    end
    check("beat_count", rec_q.size(), exp_q.size());
  endtask

  vec_t tbl[8];
  int   nb, di;

  initial begin
    reset = 1'b0; start = 1'b0; base_C = '0; dim_row = '0; dim_col = '0; In = '0;
    mem.write_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_write", mem.write, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", mem.write_addr, 0);
    check("reset_data", mem.writedata, 0);
    check("reset_mask", mem.write_mask, 0);
    reset = 1'b1;

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        tile_m[r][c] = 32'(8*r + c + 1);

    tbl[0] = '{6'd8, 6'd8,  12'd999,  16, 128'h00000004_00000003_00000002_00000001, 12'd1003, 12'd1059, 4'hF};
    tbl[1] = '{6'd3, 6'd6,  12'd100,  6,  128'h00000004_00000003_00000002_00000001, 12'd104,  12'd116,  4'h3};
    tbl[2] = '{6'd0, 6'd8,  12'd50,   0,  128'h0, 12'd0, 12'd0, 4'h0};
    tbl[3] = '{6'd8, 6'd0,  12'd50,   0,  128'h0, 12'd0, 12'd0, 4'h0};
    tbl[4] = '{6'd8, 6'd12, 12'd0,    16, 128'h00000004_00000003_00000002_00000001, 12'd4,    12'd60,   4'hF};
    tbl[5] = '{6'd2, 6'd3,  12'd10,   2,  128'h00000000_00000003_00000002_00000001, 12'd13,   12'd13,   4'h7};
    tbl[6] = '{6'd5, 6'd8,  12'd4094, 10, 128'h00000004_00000003_00000002_00000001, 12'd2,    12'd34,   4'hF};
    tbl[7] = '{6'd1, 6'd63, 12'd20,   2,  128'h00000004_00000003_00000002_00000001, 12'd24,   12'd24,   4'hF};

    foreach (tbl[i]) begin
      run(tbl[i].base, tbl[i].dr, tbl[i].dc, 0, -1, -1, nb, di);
      check("tbl_nbeats", rec_q.size(), tbl[i].nbeats);
      check("tbl_busy_cycles", nb, tbl[i].nbeats);
      check("tbl_done_cycle", di, tbl[i].nbeats);
      if (rec_q.size() == tbl[i].nbeats && tbl[i].nbeats > 1) begin
        check("tbl_first_addr", rec_q[0].addr, tbl[i].base);
        check("tbl_first_data", rec_q[0].data, tbl[i].first_data);
        check("tbl_addr1", rec_q[1].addr, tbl[i].addr1);
        check("tbl_last_addr", rec_q[tbl[i].nbeats-1].addr, tbl[i].last_addr);
        check("tbl_last_mask", rec_q[tbl[i].nbeats-1].mask, tbl[i].last_mask);
      end
    end

    run(12'd999, 6'd8, 6'd8, 1, -1, -1, nb, di);
    check("bp_accepted", rec_q.size(), 16);
    check("bp_stalled_busy", nb > 16, 1);

    run(12'd200, 6'd8, 6'd8, 0, -1, 3, nb, di);
    check("busy_start_beats", rec_q.size(), 16);
    check("busy_start_last_addr", rec_q[rec_q.size()-1].addr, 12'd260);

    run(12'd300, 6'd8, 6'd8, 0, 5, -1, nb, di);
    run(12'd300, 6'd8, 6'd8, 0, -1, -1, nb, di);
    check("post_reset_beats", rec_q.size(), 16);

    for (int n = 0; n < 25; n++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          tile_m[r][c] = $urandom;
      run(12'($urandom_range(0, 4095)), 6'($urandom_range(0, 12)), 6'($urandom_range(0, 12)),
          2, -1, -1, nb, di);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
